game_sequencer: RTL and testbench
=================================

# game_sequencer

Single-clock controller that sequences the game datapath: debounces the start/restart button, runs the START/PLAY/OVER state machine, advances the obstacle, detects collisions and accumulates the BCD score with speed scaling. Sits between the screen driver's frame pulse and the pattern generator. Every game-state change happens on the frame boundary, so the generator only ever renders a consistent snapshot.

## Interface
- DEBOUNCE_CYCLES, 270000: cycles of stable input needed to accept a button level change (10 ms at 27 MHz).
- SCORE_DIV_FRAMES, 6: PLAY frames per score increment.
- SPEED_STEP, 200: score points per speed increase.
- MAX_SPEED, 8: speed_factor ceiling (≤15).
- SCREEN_WIDTH, 128; OBS_WIDTH, 8; CAT_X, 36; CAT_WIDTH, 16: geometry in columns.
- CLK_27MHZ  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse from the screen driver at the start of each frame.
- button  in  1  raw, asynchronous, active-low (0 = pressed).
- jump_active  in  1  from the jump controller; 1 = cat airborne.
- state  out  2  00 START, 01 PLAY, 10 OVER.
- gameon  out  1  state == PLAY.
- score_bcd  out  16  four BCD digits, [15:12] thousands … [3:0] ones.
- speed_factor  out  4  current obstacle step, 1..MAX_SPEED.
- obs_end  out  8  exclusive right edge of obstacle; it occupies columns [obs_end-OBS_WIDTH, obs_end).
- frame_update  out  1  one-cycle pulse: registered outputs were updated this cycle.

## Operation
- Button path:
  - Two-flop synchronizer, then debounce.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any return to the current level clears the counter.
  - A debounced 1→0 transition sets press_pending. Only press_pending affects the FSM.
- All game state updates only on cycles with frame_start=1. press_pending is cleared on every frame_start, whatever the state.
- START:
  - Holds score=0, speed_factor=1, obs_end=SCREEN_WIDTH+OBS_WIDTH (136), frame divider=0, speed accumulator=0.
  - press_pending at frame_start → PLAY.
- PLAY, per frame_start, in this order:
  - Collision is checked against the pre-update obs_end: !jump_active && obs_end > CAT_X && obs_end-OBS_WIDTH < CAT_X+CAT_WIDTH, i.e. 36 < obs_end < 60 with defaults.
  - On collision → OVER, with obs_end, score and speed frozen this frame.
  - Otherwise move the obstacle. If obs_end ≤ speed_factor, reload 136; else obs_end -= speed_factor.
  - Advance the frame divider. When it reaches SCORE_DIV_FRAMES-1 it wraps to 0 and score += speed_factor (BCD add with carry chain).
  - The speed accumulator adds the same increment. When it reaches ≥ SPEED_STEP, subtract SPEED_STEP and increment speed_factor, saturating at MAX_SPEED.
  - The new speed applies from the next frame.
  - press_pending is ignored in PLAY.
- Score saturates at 9999: any increment that would exceed it yields 9999.
- OVER:
  - All values are held.
  - press_pending at frame_start → START, with START values loaded on the same edge.
- Illegal state 11 → START on the next clock, regardless of frame_start.

## Timing
- Reset values:
  - state=START, gameon=0, score_bcd=0000, speed_factor=1, obs_end=136, frame_update=0.
  - Both synchronizer flops and the debounced level = 1, debounce counter=0, press_pending=0.
- Reset has priority over everything. Asserting it mid-game returns to START on the next edge, and any pending press is lost.
- Press latency:
  - 2 sync cycles + DEBOUNCE_CYCLES until press_pending sets.
  - The state changes on the next frame_start edge; outputs are visible the cycle after frame_start.
- If press_pending sets on the same cycle as frame_start, that frame does not act on it; it is cleared anyway.
- frame_update is high exactly one cycle after each frame_start, in all states. All outputs are stable from frame_update until the next frame_start.
- frame_start pulses are assumed ≥2 cycles apart. Back-to-back pulses are each processed as separate frames.

## Test plan
Benches use DEBOUNCE_CYCLES=4, SCORE_DIV_FRAMES=2, SPEED_STEP=20, MAX_SPEED=3.

- Bounce filter: from reset, button 0 for 3 cycles then 1; then button 0 held for 10 cycles.
  - The first pulse is rejected; the held press sets press_pending.
  - At the next frame_start, state 00→01; the cycle after, frame_update=1.
- Obstacle motion: in PLAY, jump_active=1, 20 frames.
  - obs_end goes 136,135,… decreasing by 1 per frame.
  - After a wrap from obs_end ≤ speed_factor, obs_end returns to 136.
- Collision: in PLAY with jump_active=0, frame_start while obs_end=59 → state=OVER; obs_end stays 59 and score is unchanged.
  - With jump_active=1 at obs_end=59 → no transition.
  - Boundary: obs_end=36 and obs_end=60 do not collide.
- Score and speed: jump_active=1, 40 frames.
  - Score increments on every 2nd frame: 0001 after frame 2, and so on.
  - speed_factor becomes 2 at score 0020 and then saturates at 3.
  - Preloaded score 9998 with speed 3 → 9999, held.
- Restart: in OVER, press → START, score=0000, speed=1, obs_end=136.
  - A press during PLAY has no effect.
- Reset mid-game: reset asserted in PLAY with score 0012 → next cycle all reset values.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Game sequencer bus: the frame/button/jump inputs that drive the sequencer
// and the game-state snapshot it publishes to the pattern generator.
//   frame_start   1   frame pulse from the screen driver
//   button        1   raw start/restart button, active-low, asynchronous
//   jump_active   1   cat airborne (suppresses collision)
//   state         2   00 START, 01 PLAY, 10 OVER
//   gameon        1   state == PLAY
//   score_bcd     16  four BCD digits, thousands in [15:12]
//   speed_factor  4   obstacle step per frame
//   obs_end       8   exclusive right edge of the obstacle
//   frame_update  1   outputs refreshed this cycle
// master: the sequencer side; slave: the surrounding datapath side.
interface game_sequencer_if;
  logic        frame_start;
  logic        button;
  logic        jump_active;
  logic [1:0]  state;
  logic        gameon;
  logic [15:0] score_bcd;
  logic [3:0]  speed_factor;
  logic [7:0]  obs_end;
  logic        frame_update;

  modport master (
    input  frame_start, button, jump_active,
    output state, gameon, score_bcd, speed_factor, obs_end, frame_update
  );

  modport slave (
    output frame_start, button, jump_active,
    input  state, gameon, score_bcd, speed_factor, obs_end, frame_update
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: debounces the start button, runs the START/PLAY/OVER game
// FSM, moves the obstacle, detects collisions and accumulates a saturating
// BCD score with speed scaling. All game state changes on frame_start so the
// pattern generator always renders a consistent snapshot.
// Ports:
//   CLK_27MHZ  in   system clock
//   reset      in   synchronous, active-high
//   bus        game_sequencer_if.master (frame_start, button, jump_active in;
//              state, gameon, score_bcd, speed_factor, obs_end,
//              frame_update out, all registered)
module game_sequencer #(
  parameter int DEBOUNCE_CYCLES  = 270000,
  parameter int SCORE_DIV_FRAMES = 6,
  parameter int SPEED_STEP       = 200,
  parameter int MAX_SPEED        = 8,
  parameter int SCREEN_WIDTH     = 128,
  parameter int OBS_WIDTH        = 8,
  parameter int CAT_X            = 36,
  parameter int CAT_WIDTH        = 16
) (
  input logic              CLK_27MHZ,
  input logic              reset,
  game_sequencer_if.master bus
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W = (SCORE_DIV_FRAMES > 1) ? $clog2(SCORE_DIV_FRAMES) : 1;

  localparam logic [7:0]       OBS_RELOAD = 8'(SCREEN_WIDTH + OBS_WIDTH);
  // Overlap test 36 < obs_end < 60 (defaults), done in 10 bits so that
  // obs_end - OBS_WIDTH never has to be formed and cannot underflow.
  localparam logic [9:0]       HIT_LO     = 10'(CAT_X);
  localparam logic [9:0]       HIT_HI     = 10'(CAT_X + CAT_WIDTH + OBS_WIDTH);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCORE_DIV_FRAMES - 1);
  localparam logic [15:0]      STEP       = 16'(SPEED_STEP);
  localparam logic [3:0]       SPEED_MAX  = 4'(MAX_SPEED);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10
  } game_state_e;

  // Adds inc (0..15) to a 4-digit BCD value; any overflow past 9999 saturates.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [3:0] inc);
    logic [15:0] inc_v;
    logic [15:0] r;
    logic [4:0]  d;
    logic        carry;
    inc_v = (inc >= 4'd10) ? {8'd0, 4'd1, inc - 4'd10} : {12'd0, inc};
    r     = 16'd0;
    carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[i*4 +: 4]} + {1'b0, inc_v[i*4 +: 4]} + {4'd0, carry};
      if (d > 5'd9) begin
        d     = d + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      r[i*4 +: 4] = d[3:0];
    end
    if (carry) begin
      r = 16'h9999;
    end
    return r;
  endfunction

  logic             sync1_r, sync2_r, db_level_r, press_pending_r;
  logic [DB_W-1:0]  db_cnt_r;
  game_state_e      state_r;
  logic             gameon_r, frame_update_r;
  logic [15:0]      score_r, acc_r;
  logic [3:0]       speed_r;
  logic [7:0]       obs_r;
  logic [DIV_W-1:0] div_r;

  logic             db_fall_s, collide_s, div_wrap_s;
  logic [7:0]       obs_move_s;
  logic [15:0]      score_inc_s, acc_sum_s, acc_next_s;
  logic [3:0]       speed_next_s;

  // Debounced level is about to go 1->0 this edge: a new accepted press.
  assign db_fall_s = db_level_r & ~sync2_r & (db_cnt_r == DB_LAST);

  // Button synchronizer and debounce counter.
  always_ff @(posedge CLK_27MHZ) begin
    if (reset) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      db_level_r <= 1'b1;
      db_cnt_r   <= {DB_W{1'b0}};
    end else begin
      sync1_r <= bus.button;
      sync2_r <= sync1_r;
      if (sync2_r != db_level_r) begin
        if (db_cnt_r == DB_LAST) begin
          db_level_r <= sync2_r;
          db_cnt_r   <= {DB_W{1'b0}};
        end else begin
          db_cnt_r <= db_cnt_r + DB_W'(1'b1);
        end
      end else begin
        db_cnt_r <= {DB_W{1'b0}};
      end
    end
  end

  // Press latch; every frame consumes it, including a press landing on that edge.
  always_ff @(posedge CLK_27MHZ) begin
    if (reset) begin
      press_pending_r <= 1'b0;
    end else if (bus.frame_start) begin
      press_pending_r <= 1'b0;
    end else if (db_fall_s) begin
      press_pending_r <= 1'b1;
    end
  end

  // Next-frame candidates for collision, obstacle, score and speed.
  always_comb begin
    collide_s    = 1'b0;
    obs_move_s   = obs_r;
    div_wrap_s   = (div_r == DIV_LAST);
    score_inc_s  = bcd_add_sat(score_r, speed_r);
    acc_sum_s    = acc_r + {12'd0, speed_r};
    acc_next_s   = acc_sum_s;
    speed_next_s = speed_r;
    if (!bus.jump_active) begin
      collide_s = ({2'b00, obs_r} > HIT_LO) && ({2'b00, obs_r} < HIT_HI);
    end else begin
      collide_s = 1'b0;
    end
    if (obs_r <= {4'd0, speed_r}) begin
      obs_move_s = OBS_RELOAD;
    end else begin
      obs_move_s = obs_r - {4'd0, speed_r};
    end
    if (acc_sum_s >= STEP) begin
      acc_next_s   = acc_sum_s - STEP;
      speed_next_s = (speed_r < SPEED_MAX) ? speed_r + 4'd1 : speed_r;
    end else begin
      acc_next_s   = acc_sum_s;
      speed_next_s = speed_r;
    end
  end

  // Game FSM with registered outputs; game state moves only on frame_start.
  always_ff @(posedge CLK_27MHZ) begin
    if (reset) begin
      state_r        <= ST_START;
      gameon_r       <= 1'b0;
      score_r        <= 16'd0;
      speed_r        <= 4'd1;
      obs_r          <= OBS_RELOAD;
      div_r          <= {DIV_W{1'b0}};
      acc_r          <= 16'd0;
      frame_update_r <= 1'b0;
    end else begin
      frame_update_r <= bus.frame_start;
      case (state_r)
        ST_START: begin
          if (bus.frame_start) begin
            score_r <= 16'd0;
            speed_r <= 4'd1;
            obs_r   <= OBS_RELOAD;
            div_r   <= {DIV_W{1'b0}};
            acc_r   <= 16'd0;
            if (press_pending_r) begin
              state_r  <= ST_PLAY;
              gameon_r <= 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (bus.frame_start) begin
            if (collide_s) begin
              state_r  <= ST_OVER;
              gameon_r <= 1'b0;
            end else begin
              obs_r <= obs_move_s;
              if (div_wrap_s) begin
                div_r   <= {DIV_W{1'b0}};
                score_r <= score_inc_s;
                acc_r   <= acc_next_s;
                speed_r <= speed_next_s;
              end else begin
                div_r <= div_r + DIV_W'(1'b1);
              end
            end
          end
        end
        ST_OVER: begin
          if (bus.frame_start && press_pending_r) begin
            state_r  <= ST_START;
            gameon_r <= 1'b0;
            score_r  <= 16'd0;
            speed_r  <= 4'd1;
            obs_r    <= OBS_RELOAD;
            div_r    <= {DIV_W{1'b0}};
            acc_r    <= 16'd0;
          end
        end
        default: begin
          // Unreachable encoding 11: recover to START immediately.
          state_r  <= ST_START;
          gameon_r <= 1'b0;
          score_r  <= 16'd0;
          speed_r  <= 4'd1;
          obs_r    <= OBS_RELOAD;
          div_r    <= {DIV_W{1'b0}};
          acc_r    <= 16'd0;
        end
      endcase
    end
  end

  assign bus.state        = state_r;
  assign bus.gameon       = gameon_r;
  assign bus.score_bcd    = score_r;
  assign bus.speed_factor = speed_r;
  assign bus.obs_end      = obs_r;
  assign bus.frame_update = frame_update_r;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;
  logic clk;
  logic reset;
  game_sequencer_if bus();

  game_sequencer #(
    .DEBOUNCE_CYCLES(4), .SCORE_DIV_FRAMES(2), .SPEED_STEP(20), .MAX_SPEED(3)
  ) dut (
    .CLK_27MHZ(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [30:0] snap_t;   // {state, gameon, score_bcd, speed, obs_end}
  snap_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model of the game (test parameters: div 2, step 20, max 3).
  int m_state, m_score, m_speed, m_obs, m_div, m_acc;
  bit m_press;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic snap_t model_snap();
    return {2'(m_state), (m_state == 1) ? 1'b1 : 1'b0, to_bcd(m_score), 4'(m_speed), 8'(m_obs)};
  endfunction

  function automatic snap_t dut_snap();
    return {bus.state, bus.gameon, bus.score_bcd, bus.speed_factor, bus.obs_end};
  endfunction

  task automatic model_defaults();
    m_score = 0; m_speed = 1; m_obs = 136; m_div = 0; m_acc = 0;
  endtask

  task automatic model_frame(input bit j);
    int inc;
    case (m_state)
      0: if (m_press) m_state = 1;
      1: begin
        if (!j && m_obs > 36 && m_obs < 60) begin
          m_state = 2;
        end else begin
          m_obs = (m_obs <= m_speed) ? 136 : m_obs - m_speed;
          if (m_div == 1) begin
            m_div = 0;
            inc = m_speed;
            m_score = (m_score + inc > 9999) ? 9999 : m_score + inc;
            m_acc += inc;
            if (m_acc >= 20) begin
              m_acc -= 20;
              if (m_speed < 3) m_speed++;
            end
          end else begin
            m_div++;
          end
        end
      end
      2: if (m_press) begin
        m_state = 0;
        model_defaults();
      end
      default: m_state = 0;
    endcase
    m_press = 1'b0;
  endtask

  // One frame: push the expected snapshot, pulse frame_start, compare at frame_update.
  task automatic do_frame(input bit j, input string tag);
    int waited;
    snap_t exp_s;
    @(negedge clk);
    bus.jump_active = j;
    model_frame(j);
    sb_q.push_back(model_snap());
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    waited = 1;
    while (!bus.frame_update && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_fu_latency"}, 32'(waited), 32'd1);
    exp_s = sb_q.pop_front();
    check(tag, {1'b0, dut_snap()}, {1'b0, exp_s});
    @(negedge clk);
    check({tag, "_fu_clear"}, {31'd0, bus.frame_update}, 32'd0);
  endtask

  // Clean press: hold low long enough to debounce, then release fully.
  task automatic press(input string tag);
    @(negedge clk);
    bus.button = 1'b0;
    repeat (10) @(negedge clk);
    check({tag, "_pending"}, {31'd0, dut.press_pending_r}, 32'd1);
    m_press = 1'b1;
    bus.button = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_snap"}, {1'b0, dut_snap()}, {1'b0, 2'b00, 1'b0, 16'h0000, 4'd1, 8'd136});
    check({tag, "_fu"}, {31'd0, bus.frame_update}, 32'd0);
    check({tag, "_pp"}, {31'd0, dut.press_pending_r}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    bus.frame_start = 1'b0;
    bus.button = 1'b1;
    bus.jump_active = 1'b0;
    m_state = 0; m_press = 1'b0;
    model_defaults();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // Bounce: 3 low cycles are one short of the debounce window.
    @(negedge clk);
    bus.button = 1'b0;
    repeat (3) @(negedge clk);
    bus.button = 1'b1;
    repeat (10) @(negedge clk);
    check("bounce_rejected", {31'd0, dut.press_pending_r}, 32'd0);
    do_frame(1'b1, "start_idle");

    press("first_press");
    do_frame(1'b1, "start_to_play");

    for (int i = 0; i < 20; i++) do_frame(1'b1, "motion");

    n = 0;
    while (m_obs > 60 && n < 200) begin do_frame(1'b1, "approach"); n++; end
    do_frame(1'b0, "edge_hi_nohit");
    do_frame(1'b1, "in_range_jump");
    n = 0;
    while (m_obs > 36 && n < 200) begin do_frame(1'b1, "approach_lo"); n++; end
    do_frame(1'b0, "below_range_nohit");

    press("press_in_play");
    do_frame(1'b1, "play_ignores_press");

    n = 0;
    while (m_score < 9999 && n < 8000) begin do_frame(1'b1, "score_run"); n++; end
    for (int i = 0; i < 4; i++) do_frame(1'b1, "score_sat");

    n = 0;
    while (!(m_obs > 60 && m_obs <= 63) && n < 200) begin do_frame(1'b1, "to_hit"); n++; end
    n = 0;
    while (m_state == 1 && n < 5) begin do_frame(1'b0, "collide"); n++; end
    do_frame(1'b1, "over_hold");

    press("restart_press");
    do_frame(1'b1, "over_to_start");
    do_frame(1'b1, "start_hold");
    press("replay_press");
    do_frame(1'b1, "replay");

    n = 0;
    while (m_score < 12 && n < 100) begin do_frame(1'b1, "to_12"); n++; end
    press("pre_reset_press");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_reset");
    reset = 1'b0;
    m_state = 0; m_press = 1'b0;
    model_defaults();
    do_frame(1'b1, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
